// File: rtl/fifo_access_ctrl.sv
`default_nettype none
// ============================================================================
// fifo_access_ctrl : round-robin write arbiter, skid-buffered read drain and
//                    enable/flush sequencing in front of a synchronous FIFO
// Revision: 1.0
// ============================================================================
module fifo_access_ctrl #(
   parameter int DATA_WIDTH = 16,
   parameter int NUM_REQ    = 4,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          ctrl_enable,
   input  logic                          flush_req,
   output logic                          flush_done,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [DATA_WIDTH-1:0]         out_data,
   output logic                          fifo_wr_en,
   output logic [DATA_WIDTH-1:0]         fifo_data_in,
   output logic                          fifo_rd_en,
   input  logic [DATA_WIDTH-1:0]         fifo_data_out,
   input  logic                          fifo_full,
   input  logic                          fifo_empty,
   input  logic                          fifo_wr_ack,
   input  logic                          fifo_overflow,
   input  logic                          fifo_underflow,
   output logic [CNT_WIDTH-1:0]          wr_count,
   output logic [CNT_WIDTH-1:0]          rd_count,
   output logic                          err_ack,
   output logic                          err_overflow,
   output logic                          err_underflow
);

   localparam int                 c_PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [c_PTR_W:0]   c_NREQ  = (c_PTR_W+1)'(NUM_REQ);
   localparam logic [NUM_REQ-1:0] c_ONE   = NUM_REQ'(1);

   typedef enum logic [1:0] {
      ST_DISABLED = 2'd0,
      ST_RUN      = 2'd1,
      ST_FLUSH    = 2'd2
   } state_t;

   state_t                 r_state;
   logic                   r_flush_done;
   logic [c_PTR_W-1:0]     r_rr_ptr;
   logic [1:0]             r_occ;
   logic                   r_infl;
   logic [DATA_WIDTH-1:0]  r_skid0;
   logic [DATA_WIDTH-1:0]  r_skid1;
   logic                   r_wr_en_d;
   logic [CNT_WIDTH-1:0]   r_wr_count;
   logic [CNT_WIDTH-1:0]   r_rd_count;
   logic                   r_err_ack;
   logic                   r_err_overflow;
   logic                   r_err_underflow;

   logic                   w_run;
   logic                   w_flush;
   logic                   w_any;
   logic [c_PTR_W-1:0]     w_winner;
   logic [c_PTR_W:0]       w_sum;
   logic [c_PTR_W-1:0]     w_idx;
   logic [DATA_WIDTH-1:0]  w_win_data;
   logic                   w_grant;
   logic                   w_pop;
   logic                   w_push;
   logic                   w_rd_room;

   assign w_run   = (r_state == ST_RUN);
   assign w_flush = (r_state == ST_FLUSH);

   // Scan from the highest offset down so the lowest offset from rr_ptr wins.
   always_comb begin
      w_any    = 1'b0;
      w_winner = '0;
      w_sum    = '0;
      w_idx    = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         w_sum = {1'b0, r_rr_ptr} + (c_PTR_W+1)'(k);
         if (w_sum >= c_NREQ) begin
            w_sum = w_sum - c_NREQ;
         end
         w_idx = w_sum[c_PTR_W-1:0];
         if (req_valid[w_idx]) begin
            w_any    = 1'b1;
            w_winner = w_idx;
         end
      end
   end

   always_comb begin
      w_win_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_winner == c_PTR_W'(i)) begin
            w_win_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign w_grant      = w_run & w_any & ~fifo_full;
   assign fifo_wr_en   = w_grant;
   assign req_ready    = w_grant ? (c_ONE << w_winner) : '0;
   assign fifo_data_in = w_run ? w_win_data : '0;

   assign out_valid = (r_occ != 2'd0);
   assign out_data  = r_skid0;
   assign w_pop     = out_valid & out_ready;
   // Landing data is dropped while flushing or when a flush is starting.
   assign w_push    = r_infl & ~w_flush & ~flush_req;
   assign w_rd_room = (3'({1'b0, r_occ}) + {2'b00, r_infl}) < (3'd2 + {2'b00, w_pop});
   assign fifo_rd_en = ~fifo_empty & (w_flush | (w_run & w_rd_room));

   assign flush_done    = r_flush_done;
   assign wr_count      = r_wr_count;
   assign rd_count      = r_rd_count;
   assign err_ack       = r_err_ack;
   assign err_overflow  = r_err_overflow;
   assign err_underflow = r_err_underflow;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_DISABLED;
         r_flush_done <= 1'b0;
      end else begin
         r_flush_done <= 1'b0;
         if (flush_req) begin
            r_state <= ST_FLUSH;
         end else begin
            case (r_state)
               ST_DISABLED: if (ctrl_enable) r_state <= ST_RUN;
               ST_RUN: begin
                  if (!ctrl_enable && r_occ == 2'd0 && !r_infl) begin
                     r_state <= ST_DISABLED;
                  end
               end
               ST_FLUSH: begin
                  if (fifo_empty && !r_infl) begin
                     r_state      <= ctrl_enable ? ST_RUN : ST_DISABLED;
                     r_flush_done <= 1'b1;
                  end
               end
               default: r_state <= ST_DISABLED;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rr_ptr <= '0;
      end else if (w_grant) begin
         r_rr_ptr <= (w_winner == c_PTR_W'(NUM_REQ - 1)) ? '0 : w_winner + c_PTR_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_occ   <= 2'd0;
         r_infl  <= 1'b0;
         r_skid0 <= '0;
         r_skid1 <= '0;
      end else begin
         r_infl <= fifo_rd_en;
         if (flush_req) begin
            r_occ <= 2'd0;
         end else begin
            case ({w_push, w_pop})
               2'b10: begin
                  if (r_occ == 2'd0) r_skid0 <= fifo_data_out;
                  else               r_skid1 <= fifo_data_out;
                  r_occ <= r_occ + 2'd1;
               end
               2'b01: begin
                  r_skid0 <= r_skid1;
                  r_occ   <= r_occ - 2'd1;
               end
               2'b11: begin
                  if (r_occ == 2'd1) begin
                     r_skid0 <= fifo_data_out;
                  end else begin
                     r_skid0 <= r_skid1;
                     r_skid1 <= fifo_data_out;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_en_d       <= 1'b0;
         r_wr_count      <= '0;
         r_rd_count      <= '0;
         r_err_ack       <= 1'b0;
         r_err_overflow  <= 1'b0;
         r_err_underflow <= 1'b0;
      end else begin
         r_wr_en_d <= fifo_wr_en;
         if (fifo_wr_en) r_wr_count <= r_wr_count + CNT_WIDTH'(1);
         if (w_pop)      r_rd_count <= r_rd_count + CNT_WIDTH'(1);
         // Ack must echo the write request issued one cycle earlier.
         if (fifo_wr_ack != r_wr_en_d) r_err_ack <= 1'b1;
         if (fifo_overflow)            r_err_overflow <= 1'b1;
         if (fifo_underflow)           r_err_underflow <= 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fifo_access_ctrl.sv
`default_nettype none
// ============================================================================
// tb_fifo_access_ctrl : scoreboard bench with a behavioural 8-deep FIFO model
// Revision: 1.0
// ============================================================================
module tb_fifo_access_ctrl;
   localparam int DW = 16;
   localparam int NR = 4;
   localparam int CW = 16;
   localparam int DEPTH = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          ctrl_enable;
   logic          flush_req;
   logic          flush_done;
   logic [NR-1:0] req_valid;
   logic [NR*DW-1:0] req_data;
   logic [NR-1:0] req_ready;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic          fifo_wr_en;
   logic [DW-1:0] fifo_data_in;
   logic          fifo_rd_en;
   logic [DW-1:0] fifo_data_out;
   logic          fifo_full;
   logic          fifo_empty;
   logic          fifo_wr_ack;
   logic          fifo_overflow;
   logic          fifo_underflow;
   logic [CW-1:0] wr_count;
   logic [CW-1:0] rd_count;
   logic          err_ack;
   logic          err_overflow;
   logic          err_underflow;

   always #5 clk = ~clk;

   fifo_access_ctrl #(.DATA_WIDTH(DW), .NUM_REQ(NR), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst_n(rst_n), .ctrl_enable(ctrl_enable), .flush_req(flush_req),
      .flush_done(flush_done), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .fifo_wr_en(fifo_wr_en), .fifo_data_in(fifo_data_in),
      .fifo_rd_en(fifo_rd_en), .fifo_data_out(fifo_data_out), .fifo_full(fifo_full),
      .fifo_empty(fifo_empty), .fifo_wr_ack(fifo_wr_ack), .fifo_overflow(fifo_overflow),
      .fifo_underflow(fifo_underflow), .wr_count(wr_count), .rd_count(rd_count),
      .err_ack(err_ack), .err_overflow(err_overflow), .err_underflow(err_underflow)
   );

   // Behavioural synchronous FIFO with registered read data
   logic [DW-1:0] fq[$];
   int            fcnt = 0;
   logic          force_ack = 1'b0;
   assign fifo_full  = (fcnt == DEPTH);
   assign fifo_empty = (fcnt == 0);

   always @(posedge clk) begin
      if (!rst_n) begin
         fq.delete();
         fcnt           <= 0;
         fifo_data_out  <= '0;
         fifo_wr_ack    <= 1'b0;
         fifo_overflow  <= 1'b0;
         fifo_underflow <= 1'b0;
      end else begin
         fifo_underflow <= fifo_rd_en && fifo_empty;
         fifo_overflow  <= fifo_wr_en && fifo_full;
         fifo_wr_ack    <= (fifo_wr_en && !fifo_full) || force_ack;
         if (fifo_rd_en && !fifo_empty) fifo_data_out <= fq.pop_front();
         if (fifo_wr_en && !fifo_full)  fq.push_back(fifo_data_in);
         fcnt <= fq.size();
      end
   end

   int            checks = 0;
   int            errors = 0;
   logic [DW-1:0] exp_q[$];
   int            cyc = 0;
   logic          stab_en = 1'b0;
   logic          lat_arm = 1'b0;
   logic          prev_stall = 1'b0;
   logic [DW-1:0] prev_data = '0;
   int            t_rd = -1;
   int            t_v = -1;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // Output monitor: pops the scoreboard on every consumer transfer
   always @(negedge clk) begin
      if (rst_n) begin
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_out actual=%0h required=none", out_data);
            end else begin
               chk("out_data", out_data, exp_q.pop_front());
            end
         end
         if (stab_en && prev_stall) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_data", out_data, prev_data);
         end
         prev_stall = stab_en && out_valid && !out_ready;
         prev_data  = out_data;
         if (lat_arm) begin
            if (fifo_rd_en && t_rd < 0) t_rd = cyc;
            if (out_valid && t_v < 0)   t_v = cyc;
         end
      end else begin
         prev_stall = 1'b0;
      end
   end

   int            rem[NR];
   logic [DW-1:0] nextd[NR];
   logic [NR-1:0] last_hs;
   logic          tog = 1'b0;
   logic          bp_chk = 1'b0;
   int            full_seen = 0;
   int            fd_cnt = 0;
   int            ov_cnt = 0;

   task automatic apply();
      for (int i = 0; i < NR; i++) begin
         req_valid[i] = (rem[i] > 0);
         req_data[i*DW +: DW] = nextd[i];
      end
   endtask

   task automatic tick();
      @(negedge clk);
      last_hs = req_valid & req_ready;
      if (bp_chk && fifo_full) begin
         full_seen++;
         chk("full_wr_en", fifo_wr_en, 0);
         chk("full_ready", req_ready, 0);
      end
      if (flush_done) fd_cnt++;
      if (out_valid)  ov_cnt++;
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) begin
         if (last_hs[i]) begin
            exp_q.push_back(nextd[i]);
            nextd[i] = nextd[i] + 16'd1;
            rem[i]--;
         end
      end
      if (tog) out_ready = ~out_ready;
      apply();
   endtask

   task automatic wait_drain();
      for (int k = 0; k < 400 && (exp_q.size() != 0 || rem[0] + rem[1] + rem[2] + rem[3] != 0); k++) tick();
      chk("drain_left", exp_q.size(), 0);
      repeat (3) tick();
   endtask

   logic [NR-1:0] g_exp[5];

   initial begin
      rst_n = 1'b0; ctrl_enable = 1'b0; flush_req = 1'b0; out_ready = 1'b0;
      req_valid = '0; req_data = '0;
      for (int i = 0; i < NR; i++) begin rem[i] = 0; nextd[i] = '0; end
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) rem[i] = 1;
      apply();
      #1;
      chk("rst_req_ready", req_ready, 0);
      chk("rst_wr_en", fifo_wr_en, 0);
      chk("rst_rd_en", fifo_rd_en, 0);
      chk("rst_out", {out_valid, out_data, flush_done}, 0);
      chk("rst_counts", {wr_count, rd_count}, 0);
      chk("rst_errs", {err_ack, err_overflow, err_underflow}, 0);
      for (int i = 0; i < NR; i++) rem[i] = 0;
      apply();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      ctrl_enable = 1'b1;
      out_ready = 1'b1;
      stab_en = 1'b1;
      tick();

      // Round-robin order with all four requesters valid
      g_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      rem[0] = 2; rem[1] = 1; rem[2] = 1; rem[3] = 1;
      for (int i = 0; i < NR; i++) nextd[i] = 16'hA000 + 16'(i * 256);
      apply();
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("grant", last_hs, g_exp[k]);
      end
      wait_drain();
      chk("wr_count_rr", wr_count, 5);
      chk("rd_count_rr", rd_count, 5);

      // Fill with consumer stalled: 8 in FIFO + 2 in skid
      out_ready = 1'b0;
      bp_chk = 1'b1;
      rem[1] = 20; nextd[1] = 16'hB000;
      apply();
      repeat (30) tick();
      bp_chk = 1'b0;
      chk("full_seen", full_seen > 0, 1);
      chk("wr_count_bp", wr_count, 15);
      chk("err_ovf_bp", err_overflow, 0);
      out_ready = 1'b1;
      wait_drain();
      chk("wr_count_bp2", wr_count, 25);
      chk("rd_count_bp2", rd_count, 25);

      // Streaming from requester 2 with read latency measurement
      t_rd = -1; t_v = -1; lat_arm = 1'b1;
      rem[2] = 16; nextd[2] = 16'h0001;
      apply();
      wait_drain();
      lat_arm = 1'b0;
      chk("rd_seen", t_rd >= 0, 1);
      chk("rd_to_valid", t_v - t_rd, 2);
      chk("rd_count_stream", rd_count, 41);

      // Consumer toggling ready every cycle, two competing requesters
      tog = 1'b1;
      rem[0] = 8; nextd[0] = 16'h0C00;
      rem[3] = 8; nextd[3] = 16'h3C00;
      apply();
      wait_drain();
      tog = 1'b0;
      out_ready = 1'b1;
      repeat (2) tick();
      chk("rd_count_stall", rd_count, 57);
      chk("wr_count_stall", wr_count, 57);

      // Disabled: no grants even with requests pending
      ctrl_enable = 1'b0;
      repeat (3) tick();
      rem[1] = 3;
      apply();
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("dis_grant", last_hs, 0);
      end
      rem[1] = 0;
      apply();
      ctrl_enable = 1'b1;
      repeat (2) tick();

      // Flush with 5 entries queued and the consumer stalled
      out_ready = 1'b0;
      rem[2] = 5; nextd[2] = 16'hF000;
      apply();
      repeat (10) tick();
      chk("pre_flush_valid", out_valid, 1);
      stab_en = 1'b0;
      exp_q.delete();
      flush_req = 1'b1;
      tick();
      flush_req = 1'b0;
      out_ready = 1'b1;
      fd_cnt = 0; ov_cnt = 0;
      repeat (30) tick();
      chk("flush_done_cnt", fd_cnt, 1);
      chk("flush_out_valid", ov_cnt, 0);
      chk("flush_rd_count", rd_count, 57);
      chk("flush_wr_count", wr_count, 62);
      chk("flush_empty", fifo_empty, 1);
      stab_en = 1'b1;

      // Sticky error flags
      chk("err_ack_pre", err_ack, 0);
      chk("err_ovf_pre", err_overflow, 0);
      chk("err_unf_pre", err_underflow, 0);
      force_ack = 1'b1;
      tick();
      force_ack = 1'b0;
      repeat (2) tick();
      chk("err_ack_set", err_ack, 1);
      repeat (5) tick();
      chk("err_ack_sticky", err_ack, 1);
      chk("err_ovf_post", err_overflow, 0);
      rst_n = 1'b0;
      #2;
      chk("err_ack_rst", err_ack, 0);
      chk("counts_rst", {wr_count, rd_count}, 0);
      chk("out_valid_rst", out_valid, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end
endmodule
`default_nettype wire
